pool_1: RTL

POOL_1 -- requirements
Module: pool_1

---
 rtl/pool_1.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pool_1.sv
// pool_1: 2x2 max-pooling engine between fm_bram_1 and fm_bram_2.
// Walks 6 channels x 14 row pairs from fm_bram_1; each 56-lane word carries
// two 28-wide input rows. Every word is reduced to one 14-wide pooled row;
// two pooled rows are packed into one 448-bit fm_bram_2 write.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   pool_1_en       level start; a rising edge seen in idle starts one pass
//   fm_rd_en/addr   fm_bram_1 read request (addr 0..83)
//   fm_rd_data      fm_bram_1 word, valid BRAM_RD_LAT cycles after the request
//   fm_wr_en/addr   fm_bram_2 write strobe (addr 0..41)
//   fm_wr_data      {odd pooled row, even pooled row}, held until next write
//   pool_1_finish   high from completion until pool_1_en goes low
module pool_1 #(
  parameter int unsigned BRAM_RD_LAT = 2,
  parameter int unsigned RELU_EN     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pool_1_en,
  output logic         fm_rd_en,
  output logic [6:0]   fm_rd_addr,
  input  logic [895:0] fm_rd_data,
  output logic         fm_wr_en,
  output logic [5:0]   fm_wr_addr,
  output logic [447:0] fm_wr_data,
  output logic         pool_1_finish
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] CALC  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [1:0] LAT_W = 2'(BRAM_RD_LAT);

  logic [2:0]   state_q, state_d;
  logic         en_prev_q;
  logic [2:0]   ch_q;
  logic [3:0]   row_q;
  logic [1:0]   wait_cnt_q;
  logic [895:0] word_q;
  logic [223:0] lower_q, upper_q;
  logic [223:0] pooled;
  logic [6:0]   rd_addr_c;
  logic [5:0]   wr_addr_c;
  logic         start;
  logic         last_row;
  logic         last_ch;

  assign start     = pool_1_en & ~en_prev_q;
  assign last_row  = (row_q == 4'd13);
  assign last_ch   = (ch_q == 3'd5);
  assign rd_addr_c = 7'(ch_q) * 7'd14 + 7'(row_q);
  assign wr_addr_c = 6'(ch_q) * 6'd7 + 6'(row_q >> 1);

  assign pool_1_finish = (state_q == DONE);

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Each output lane k pools the 2x2 window: lanes 2k, 2k+1 of the even row
  // and lanes 28+2k, 29+2k of the odd row.
  logic signed [15:0] m;
  always_comb begin
    pooled = '0;
    m      = '0;
    for (int k = 0; k < 14; k++) begin
      m = smax(smax(word_q[16*(2*k) +: 16], word_q[16*(2*k+1) +: 16]),
               smax(word_q[16*(28+2*k) +: 16], word_q[16*(29+2*k) +: 16]));
      if (RELU_EN != 0 && m[15]) begin
        m = '0;
      end
      pooled[16*k +: 16] = m;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = WAIT;
      WAIT:    if (wait_cnt_q == LAT_W) state_d = CALC;
      CALC:    state_d = row_q[0] ? WRITE : READ;
      WRITE:   state_d = (last_row && last_ch) ? DONE : READ;
      DONE:    if (!pool_1_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read/write strobes are registered: the request leaves READ/WRITE on the
  // clock edge, so fm_rd_en is high during the first WAIT cycle and the
  // word is valid BRAM_RD_LAT cycles later, when wait_cnt_q == BRAM_RD_LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      en_prev_q  <= 1'b1;  // a level held through reset must drop first
      ch_q       <= '0;
      row_q      <= '0;
      wait_cnt_q <= '0;
      word_q     <= '0;
      lower_q    <= '0;
      upper_q    <= '0;
      fm_rd_en   <= 1'b0;
      fm_rd_addr <= '0;
      fm_wr_en   <= 1'b0;
      fm_wr_addr <= '0;
      fm_wr_data <= '0;
    end else begin
      state_q   <= state_d;
      en_prev_q <= pool_1_en;
      fm_rd_en  <= 1'b0;
      fm_wr_en  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ch_q  <= '0;
            row_q <= '0;
          end
        end
        READ: begin
          fm_rd_en   <= 1'b1;
          fm_rd_addr <= rd_addr_c;
          wait_cnt_q <= '0;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + 2'd1;
          if (wait_cnt_q == LAT_W) begin
            word_q <= fm_rd_data;
          end
        end
        CALC: begin
          if (row_q[0]) begin
            upper_q <= pooled;
          end else begin
            lower_q <= pooled;
            row_q   <= row_q + 4'd1;
          end
        end
        WRITE: begin
          fm_wr_en   <= 1'b1;
          fm_wr_addr <= wr_addr_c;
          fm_wr_data <= {upper_q, lower_q};
          if (last_row) begin
            row_q <= '0;
            ch_q  <= ch_q + 3'd1;
          end else begin
            row_q <= row_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
